// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state type and defaults for serial_adder
`include "adder_defs.vh"

package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = `SA_DEFAULT_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = `SA_ST_IDLE,
      ST_RUN  = `SA_ST_RUN,
      ST_DONE = `SA_ST_DONE
   } state_t;

endpackage

// File: rtl/adder_defs.vh
// rtl/adder_defs.vh - shared state encodings and default operand width for serial_adder
`ifndef ADDER_DEFS_VH
`define ADDER_DEFS_VH

`define SA_ST_IDLE       2'b00
`define SA_ST_RUN        2'b01
`define SA_ST_DONE       2'b10
`define SA_DEFAULT_WIDTH 8

`endif

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder built from two half adders and an OR
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic w_s0;
   logic w_c0;
   logic w_c1;

   half_adder u_ha0 (
      .i_a (x),
      .i_b (y),
      .o_s (w_s0),
      .o_c (w_c0)
   );

   half_adder u_ha1 (
      .i_a (w_s0),
      .i_b (ci),
      .o_s (s),
      .o_c (w_c1)
   );

   assign co = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder
module half_adder (
   input  logic i_a,
   input  logic i_b,
   output logic o_s,
   output logic o_c
);

   assign o_s = i_a ^ i_b;
   assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one full-adder cell per clock
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic             w_s;
   logic             w_co;

   full_adder u_fa (
      .x  (r_a[0]),
      .y  (r_b[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   // Operands shift right so bit i sits at position 0 on the i-th RUN edge;
   // sum bits enter at the MSB and reach position i after WIDTH shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_sum   <= {w_s, r_sum[WIDTH-1:1]};
               r_carry <= w_co;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_BIT) begin
                  r_cout  <= w_co;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
